// File: rtl/sample_iterator_pkg.sv
// Shared raster definitions for the sample iterator.
// Holds the fixed-point geometry constants, the vertex, box and colour types,
// the iterator state encoding and small sign/zero-extension helpers that are
// used for overflow-free cursor arithmetic.
package sample_iterator_pkg;

    localparam int SIGFIG = 24;   // bits in colour and position
    localparam int RADIX  = 10;   // fraction bits in position
    localparam int VERTS  = 3;    // vertices per triangle
    localparam int AXIS   = 3;    // axes per vertex (x,y,z)
    localparam int COLORS = 3;    // colour channels
    localparam int SAMPS  = 4;    // sample lanes emitted per cycle, along x

    // The comparisons must not wrap. SIGFIG+1 bits covers a single
    // increment past +max. The extra bits also hold cx + SAMPS*step with an
    // unsigned step of full range.
    localparam int EXTW = SIGFIG + $clog2(SAMPS) + 2;

    // Fixed-point 1.0 (one pixel).
    localparam logic [SIGFIG-1:0] ONE = SIGFIG'(1) << RADIX;

    typedef logic signed [AXIS-1:0][SIGFIG-1:0] vertex_t;
    typedef logic signed [1:0][1:0][SIGFIG-1:0] box_t;    // [corner][axis]
    typedef logic [COLORS-1:0][SIGFIG-1:0]      color_t;
    typedef logic signed [EXTW-1:0]             ext_t;

    typedef enum logic {
        WAIT = 1'b0,
        TEST = 1'b1
    } iter_state_e;

    // Treat a SIGFIG-bit coordinate as a signed value at extended width.
    function automatic ext_t sext(input logic [SIGFIG-1:0] v);
        return ext_t'({{(EXTW-SIGFIG){v[SIGFIG-1]}}, v});
    endfunction

    // Treat a SIGFIG-bit step as an unsigned value at extended width.
    function automatic ext_t zext(input logic [SIGFIG-1:0] v);
        return ext_t'({{(EXTW-SIGFIG){1'b0}}, v});
    endfunction

    // Distance covered by one group of SAMPS lanes.
    function automatic ext_t group_span(input logic [SIGFIG-1:0] s);
        ext_t acc;
        acc = '0;
        for (int i = 0; i < SAMPS; i++) begin
            acc = acc + zext(s);
        end
        return acc;
    endfunction

endpackage

// File: rtl/sample_lane_gen.sv
// Combinational lane generator.
// Takes a cursor (cx_i, cy_i), the sample step and the right edge of the box.
// Produces SAMPS sample coordinates along x and a valid bit per lane.
//   cx_i, cy_i   : cursor position, signed fixed point
//   step_i       : sample spacing, unsigned fixed point
//   urx_i        : right edge of the bounding box, signed
//   lane_x_o     : x of each lane (cx + i*step)
//   lane_y_o     : y of each lane (always cy)
//   lane_valid_o : lane x lies inside the box (x <= urx)
module sample_lane_gen
    import sample_iterator_pkg::*;
(
    input  logic [SIGFIG-1:0]            cx_i,
    input  logic [SIGFIG-1:0]            cy_i,
    input  logic [SIGFIG-1:0]            step_i,
    input  logic [SIGFIG-1:0]            urx_i,
    output logic [SAMPS-1:0][SIGFIG-1:0] lane_x_o,
    output logic [SAMPS-1:0][SIGFIG-1:0] lane_y_o,
    output logic [SAMPS-1:0]             lane_valid_o
);

    ext_t acc;
    ext_t urx_ext;

    always_comb begin
        urx_ext      = sext(urx_i);
        acc          = sext(cx_i);
        lane_x_o     = '0;
        lane_y_o     = '0;
        lane_valid_o = '0;
        for (int i = 0; i < SAMPS; i++) begin
            // The compare happens at extended width, so a lane that runs
            // off the top of the number range is never reported as inside.
            lane_x_o[i]     = acc[SIGFIG-1:0];
            lane_y_o[i]     = cy_i;
            lane_valid_o[i] = (acc <= urx_ext);
            acc             = acc + zext(step_i);
        end
    end

endmodule

// File: rtl/sample_iterator.sv
// Sample iterator.
// Walks the bounding box of one triangle at a time and emits SAMPS sample
// positions per cycle to the sample-test stage.
//   clk, rst        : clock; asynchronous active-low reset
//   tri_R13S        : incoming triangle vertices
//   color_R13U      : incoming triangle colour
//   box_R13S        : incoming bounding box [corner 0=ll,1=ur][axis 0=x,1=y]
//   step_R13U       : sample spacing (1024 = one pixel), nonzero
//   validTri_R13H   : incoming triangle valid
//   halt_R13H       : upstream must hold its outputs
//   stall_R16H      : downstream stall; the whole block freezes
//   tri_R16S        : triangle of the samples being shown
//   color_R16U      : colour of the samples being shown
//   sample_R16S     : per lane [0]=x, [1]=y
//   validSamp_R16H  : lane carries a real sample
//   dbg_state_o     : current iterator state (0=WAIT, 1=TEST)
//
// The cursor registers always hold the group that is on the outputs. A TEST
// cycle is therefore the cycle in which its group is visible. halt_R13H tells
// upstream whether that group is the last one. At the end of the final group
// the next triangle is accepted and its first group is loaded straight into
// the output flops. This gives back-to-back triangles with no idle cycle.
module sample_iterator
    import sample_iterator_pkg::*;
(
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R13S,
    input  logic [COLORS-1:0][SIGFIG-1:0]          color_R13U,
    input  logic [1:0][1:0][SIGFIG-1:0]            box_R13S,
    input  logic [SIGFIG-1:0]                      step_R13U,
    input  logic                                   validTri_R13H,
    output logic                                   halt_R13H,
    input  logic                                   stall_R16H,
    output logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R16S,
    output logic [COLORS-1:0][SIGFIG-1:0]          color_R16U,
    output logic [1:0][SAMPS-1:0][SIGFIG-1:0]      sample_R16S,
    output logic [SAMPS-1:0]                       validSamp_R16H,
    output logic                                   dbg_state_o
);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    iter_state_e                            state_q, state_d;
    logic [SIGFIG-1:0]                      cx_q, cy_q;
    logic [SIGFIG-1:0]                      llx_q, urx_q, ury_q, step_q;
    logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_q;
    color_t                                 color_q;
    logic [1:0][SAMPS-1:0][SIGFIG-1:0]      samp_q;
    logic [SAMPS-1:0]                       valid_q;

    // ------------------------------------------------------------------
    // Incoming box decode
    // ------------------------------------------------------------------
    box_t              box_in;
    logic [SIGFIG-1:0] in_llx, in_lly, in_urx;
    logic              in_good;

    assign box_in  = box_R13S;
    assign in_llx  = box_in[0][0];
    assign in_lly  = box_in[0][1];
    assign in_urx  = box_in[1][0];
    assign in_good = (sext(box_in[0][0]) <= sext(box_in[1][0])) &&
                     (sext(box_in[0][1]) <= sext(box_in[1][1]));

    // ------------------------------------------------------------------
    // Cursor advance for the group currently on the outputs
    // ------------------------------------------------------------------
    ext_t row_x;      // cx after moving one group right
    ext_t next_y;     // cy after moving one row up
    logic row_cont;   // another group fits on this row
    logic last_grp;   // the group on the outputs ends the triangle
    logic free;       // a new triangle may be taken this cycle
    logic accept;

    assign row_x    = sext(cx_q) + group_span(step_q);
    assign next_y   = sext(cy_q) + zext(step_q);
    assign row_cont = (row_x <= sext(urx_q));
    assign last_grp = (state_q == TEST) && !row_cont && (next_y > sext(ury_q));
    assign free     = (state_q == WAIT) || last_grp;
    assign accept   = !stall_R16H && free && validTri_R13H && in_good;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= WAIT;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (stall_R16H) begin
            state_d = state_q;
        end else if (accept) begin
            state_d = TEST;
        end else if (free) begin
            // Either idle with nothing usable, or the last group went out.
            state_d = WAIT;
        end else begin
            state_d = TEST;
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs decoded from state, cursor and stall
    // ------------------------------------------------------------------
    always_comb begin
        halt_R13H   = 1'b0;
        dbg_state_o = state_q;
        if (stall_R16H) begin
            halt_R13H = 1'b1;
        end else if (state_q == TEST && !last_grp) begin
            halt_R13H = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Next cursor: the ll corner of a new triangle, or an advance of the
    // current cursor.
    // ------------------------------------------------------------------
    logic [SIGFIG-1:0]            cx_d, cy_d, gen_step, gen_urx;
    logic [SAMPS-1:0][SIGFIG-1:0] lane_x, lane_y;
    logic [SAMPS-1:0]             lane_valid;

    always_comb begin
        cx_d     = cx_q;
        cy_d     = cy_q;
        gen_step = step_q;
        gen_urx  = urx_q;
        if (accept) begin
            cx_d     = in_llx;
            cy_d     = in_lly;
            gen_step = step_R13U;
            gen_urx  = in_urx;
        end else if (row_cont) begin
            cx_d = row_x[SIGFIG-1:0];
        end else begin
            cx_d = llx_q;
            cy_d = next_y[SIGFIG-1:0];
        end
    end

    sample_lane_gen u_lane_gen (
        .cx_i         (cx_d),
        .cy_i         (cy_d),
        .step_i       (gen_step),
        .urx_i        (gen_urx),
        .lane_x_o     (lane_x),
        .lane_y_o     (lane_y),
        .lane_valid_o (lane_valid)
    );

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cx_q    <= '0;
            cy_q    <= '0;
            llx_q   <= '0;
            urx_q   <= '0;
            ury_q   <= '0;
            step_q  <= '0;
            tri_q   <= '0;
            color_q <= '0;
            samp_q  <= '0;
            valid_q <= '0;
        end else if (!stall_R16H) begin
            if (accept) begin
                llx_q   <= in_llx;
                urx_q   <= in_urx;
                ury_q   <= box_in[1][1];
                step_q  <= step_R13U;
                tri_q   <= tri_R13S;
                color_q <= color_R13U;
            end
            if (state_d == TEST) begin
                cx_q      <= cx_d;
                cy_q      <= cy_d;
                samp_q[0] <= lane_x;
                samp_q[1] <= lane_y;
                valid_q   <= lane_valid;
            end else begin
                valid_q <= '0;
            end
        end
    end

    assign tri_R16S       = tri_q;
    assign color_R16U     = color_q;
    assign sample_R16S    = samp_q;
    assign validSamp_R16H = valid_q;

endmodule

// File: tb/tb_sample_iterator.sv
module tb_sample_iterator;
  import sample_iterator_pkg::*;

  typedef logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_v_t;
  typedef logic [1:0][SAMPS-1:0][SIGFIG-1:0]      samp_v_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  tri_v_t                        tri_in;
  logic [COLORS-1:0][SIGFIG-1:0] color_in;
  logic [1:0][1:0][SIGFIG-1:0]   box_in;
  logic [SIGFIG-1:0]             step_in;
  logic                          valid_in;
  logic                          halt;
  logic                          stall;
  tri_v_t                        tri_out;
  logic [COLORS-1:0][SIGFIG-1:0] color_out;
  samp_v_t                       samp_out;
  logic [SAMPS-1:0]              vsamp_out;
  logic                          dbg_state;

  sample_iterator dut (
    .clk            (clk),
    .rst            (rst),
    .tri_R13S       (tri_in),
    .color_R13U     (color_in),
    .box_R13S       (box_in),
    .step_R13U      (step_in),
    .validTri_R13H  (valid_in),
    .halt_R13H      (halt),
    .stall_R16H     (stall),
    .tri_R16S       (tri_out),
    .color_R16U     (color_out),
    .sample_R16S    (samp_out),
    .validSamp_R16H (vsamp_out),
    .dbg_state_o    (dbg_state)
  );

  // ---------------- scoreboard counters ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver helpers ----------------
  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic tri_v_t mk_tri(input int base);
    tri_v_t t;
    for (int v = 0; v < VERTS; v++)
      for (int a = 0; a < AXIS; a++)
        t[v][a] = SIGFIG'(base + v * 16 + a);
    return t;
  endfunction

  // Expected sample group: lane i x = x0 + i*st, all lanes y.
  function automatic samp_v_t mk_samp(input int x0, input int st, input int y);
    samp_v_t s;
    for (int i = 0; i < SAMPS; i++) begin
      s[0][i] = SIGFIG'(x0 + i * st);
      s[1][i] = SIGFIG'(y);
    end
    return s;
  endfunction

  task automatic drive_tri(input int base, input int llx, input int lly,
                           input int urx, input int ury, input int st);
    tri_in   = mk_tri(base);
    color_in = {SIGFIG'(base + 3), SIGFIG'(base + 2), SIGFIG'(base + 1)};
    box_in[0][0] = SIGFIG'(llx);
    box_in[0][1] = SIGFIG'(lly);
    box_in[1][0] = SIGFIG'(urx);
    box_in[1][1] = SIGFIG'(ury);
    step_in  = SIGFIG'(st);
    valid_in = 1'b1;
  endtask

  task automatic chk_grp(input string tag, input int x0, input int st, input int y,
                         input logic [SAMPS-1:0] v, input logic h);
    chk({tag, ".samp"},  256'(samp_out),  256'(mk_samp(x0, st, y)));
    chk({tag, ".valid"}, 256'(vsamp_out), 256'(v));
    chk({tag, ".halt"},  256'(halt),      256'(h));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int one;
    one      = int'(ONE);
    tri_in   = '0;
    color_in = '0;
    box_in   = '0;
    step_in  = '0;
    valid_in = 1'b0;
    stall    = 1'b0;

    // reset state
    #2;
    chk("rst.samp",  256'(samp_out),  256'(0));
    chk("rst.valid", 256'(vsamp_out), 256'(0));
    chk("rst.tri",   256'(tri_out),   256'(0));
    chk("rst.color", 256'(color_out), 256'(0));
    chk("rst.halt",  256'(halt),      256'(0));
    chk("rst.state", 256'(dbg_state), 256'(0));
    tick();
    rst = 1'b1;
    tick();

    // basic walk: x 0..4096, y 0..1024, step 1.0
    drive_tri(16'h100, 0, 0, 4 * one, one, one);
    chk("walk.idle_halt", 256'(halt), 256'(0));
    tick();
    valid_in = 1'b0;
    chk_grp("walk.g0", 0, one, 0, 4'b1111, 1'b1);
    chk("walk.tri",   256'(tri_out),   256'(mk_tri(16'h100)));
    chk("walk.color", 256'(color_out), 256'({24'h103, 24'h102, 24'h101}));
    chk("walk.state", 256'(dbg_state), 256'(1));
    tick();
    chk_grp("walk.g1", 4096, one, 0, 4'b0001, 1'b1);
    tick();
    chk_grp("walk.g2", 0, one, 1024, 4'b1111, 1'b1);
    tick();
    chk_grp("walk.g3", 4096, one, 1024, 4'b0001, 1'b0);

    // back-to-back: single-point triangle offered during the final group
    drive_tri(16'h200, 2048, 2048, 2048, 2048, one);
    tick();
    valid_in = 1'b0;
    chk_grp("pt.g0", 2048, one, 2048, 4'b0001, 1'b0);
    chk("pt.tri",   256'(tri_out),   256'(mk_tri(16'h200)));
    chk("pt.state", 256'(dbg_state), 256'(1));
    tick();
    chk("pt.wait_valid", 256'(vsamp_out), 256'(0));
    chk("pt.wait_state", 256'(dbg_state), 256'(0));
    chk("pt.wait_halt",  256'(halt),      256'(0));

    // degenerate box is dropped
    drive_tri(16'h300, 4096, 0, 0, 0, one);
    tick();
    chk("deg.valid", 256'(vsamp_out), 256'(0));
    chk("deg.state", 256'(dbg_state), 256'(0));
    chk("deg.halt",  256'(halt),      256'(0));
    chk("deg.tri",   256'(tri_out),   256'(mk_tri(16'h200)));

    // next triangle taken on the following cycle; negative x, step 0.5
    drive_tri(16'h400, -1024, 0, 1024, 1024, 512);
    tick();
    valid_in = 1'b0;
    chk_grp("neg.g0", -1024, 512, 0, 4'b1111, 1'b1);
    chk("neg.tri", 256'(tri_out), 256'(mk_tri(16'h400)));

    // stall for 3 cycles mid-row: everything frozen
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk_grp("stall", -1024, 512, 0, 4'b1111, 1'b1);
      tick();
    end
    chk_grp("stall.end", -1024, 512, 0, 4'b1111, 1'b1);
    stall = 1'b0;
    tick();
    chk_grp("neg.g1", 1024, 512, 0, 4'b0001, 1'b1);
    tick();
    chk_grp("neg.g2", -1024, 512, 512, 4'b1111, 1'b1);
    tick();
    chk_grp("neg.g3", 1024, 512, 512, 4'b0001, 1'b1);
    tick();
    chk_grp("neg.g4", -1024, 512, 1024, 4'b1111, 1'b1);
    tick();
    chk_grp("neg.g5", 1024, 512, 1024, 4'b0001, 1'b0);
    tick();
    chk("neg.done_valid", 256'(vsamp_out), 256'(0));
    chk("neg.done_state", 256'(dbg_state), 256'(0));

    // async reset in the middle of a walk
    drive_tri(16'h500, 0, 0, 4 * one, one, one);
    tick();
    valid_in = 1'b0;
    chk_grp("rw.g0", 0, one, 0, 4'b1111, 1'b1);
    tick();
    chk_grp("rw.g1", 4096, one, 0, 4'b0001, 1'b1);
    #3;
    rst = 1'b0;
    #1;
    chk("rw.samp",  256'(samp_out),  256'(0));
    chk("rw.valid", 256'(vsamp_out), 256'(0));
    chk("rw.tri",   256'(tri_out),   256'(0));
    chk("rw.color", 256'(color_out), 256'(0));
    chk("rw.state", 256'(dbg_state), 256'(0));
    chk("rw.halt",  256'(halt),      256'(0));
    #1;
    rst = 1'b1;
    drive_tri(16'h600, 1024, 3072, 2048, 3072, one);
    tick();
    valid_in = 1'b0;
    chk_grp("post.g0", 1024, one, 3072, 4'b0011, 1'b0);
    chk("post.tri", 256'(tri_out), 256'(mk_tri(16'h600)));
    tick();
    chk("post.wait_valid", 256'(vsamp_out), 256'(0));
    chk("post.wait_state", 256'(dbg_state), 256'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
